// File: rtl/match_job_issuer.sv
// Match request initiator: filters a job's hash-chain candidates, issues one tagged
// request per usable candidate, scores out-of-order responses and emits the best match.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 8
`endif

module match_job_issuer #(
  parameter int unsigned NUM_CAND      = 4,
  parameter int unsigned TAG_BITS      = 8,
  parameter int unsigned SIZE_LOG2     = 15,
  parameter int unsigned MIN_MATCH_LEN = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              job_valid,
  output logic                              job_ready,
  input  logic [`ADDR_WIDTH-1:0]            job_head_addr,
  input  logic [NUM_CAND*`ADDR_WIDTH-1:0]   job_cand_addr,
  input  logic [NUM_CAND-1:0]               job_cand_mask,
  output logic                              match_req_valid,
  input  logic                              match_req_ready,
  output logic [TAG_BITS-1:0]               match_req_tag,
  output logic [`ADDR_WIDTH-1:0]            match_req_head_addr,
  output logic [`ADDR_WIDTH-1:0]            match_req_history_addr,
  input  logic                              match_resp_valid,
  output logic                              match_resp_ready,
  input  logic [TAG_BITS-1:0]               match_resp_tag,
  input  logic [`MAX_MATCH_LEN_LOG2:0]      match_resp_match_len,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [`ADDR_WIDTH-1:0]            res_head_addr,
  output logic [`MAX_MATCH_LEN_LOG2:0]      res_match_len,
  output logic [`ADDR_WIDTH-1:0]            res_offset,
  output logic [$clog2(NUM_CAND)-1:0]       res_cand_idx
);
  localparam int unsigned AW   = `ADDR_WIDTH;
  localparam int unsigned LW   = `MAX_MATCH_LEN_LOG2 + 1;
  localparam int unsigned CIDX = $clog2(NUM_CAND);
  localparam int unsigned SW   = TAG_BITS - CIDX;
  localparam logic [AW-1:0] WINDOW = AW'(1) << SIZE_LOG2;

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, OUTPUT} state_t;

  state_t                       state;
  logic [SW-1:0]                seq, job_seq;
  logic [AW-1:0]                head_q;
  logic [NUM_CAND-1:0][AW-1:0]  cand_q;
  logic [NUM_CAND-1:0]          issue_mask, pending, received;
  logic [LW-1:0]                best_len;
  logic [CIDX-1:0]              best_idx;

  logic [NUM_CAND-1:0][AW-1:0]  in_cand;
  logic [NUM_CAND-1:0]          in_mask;
  logic [CIDX-1:0]              first_idx, next_idx, cur_idx, resp_idx;
  logic [SW-1:0]                resp_seq;
  logic                         resp_acc;
  logic [LW-1:0]                resp_len, best_len_nx;
  logic [CIDX-1:0]              best_idx_nx;
  logic [NUM_CAND-1:0]          received_nx, pending_nx;
  logic                         win_zero;
  logic [AW-1:0]                win_off;
  logic [CIDX-1:0]              win_idx;

  function automatic logic [CIDX-1:0] lowest(input logic [NUM_CAND-1:0] m);
    lowest = '0;
    for (int i = int'(NUM_CAND) - 1; i >= 0; i--)
      if (m[i]) lowest = CIDX'(i);
  endfunction

  assign in_cand = job_cand_addr;

  // Candidate is usable only if it lies strictly behind the head and inside the window.
  always_comb begin
    in_mask = '0;
    for (int k = 0; k < int'(NUM_CAND); k++)
      in_mask[k] = job_cand_mask[k] && (in_cand[k] < job_head_addr) &&
                   ((job_head_addr - in_cand[k]) <= WINDOW);
  end

  // Response acceptance, scoring and the result that would be emitted this cycle.
  always_comb begin
    first_idx   = lowest(in_mask);
    next_idx    = lowest(pending);
    cur_idx     = match_req_tag[CIDX-1:0];
    pending_nx  = pending & ~(NUM_CAND'(1) << cur_idx);
    resp_idx    = match_resp_tag[CIDX-1:0];
    resp_seq    = match_resp_tag[TAG_BITS-1:CIDX];
    resp_acc    = match_resp_valid && match_resp_ready && (resp_seq == job_seq) &&
                  issue_mask[resp_idx] && !received[resp_idx];
    resp_len    = (match_resp_match_len < LW'(MIN_MATCH_LEN)) ? '0 : match_resp_match_len;
    received_nx = received;
    best_len_nx = best_len;
    best_idx_nx = best_idx;
    if (resp_acc) begin
      received_nx[resp_idx] = 1'b1;
      if ((resp_len > best_len) ||
          ((resp_len == best_len) && (resp_len != '0) && (resp_idx < best_idx))) begin
        best_len_nx = resp_len;
        best_idx_nx = resp_idx;
      end
    end
    win_zero = (best_len_nx == '0);
    win_off  = win_zero ? '0 : (head_q - cand_q[best_idx_nx]);
    win_idx  = win_zero ? '0 : best_idx_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                  <= IDLE;
      seq                    <= '0;
      job_seq                <= '0;
      head_q                 <= '0;
      cand_q                 <= '0;
      issue_mask             <= '0;
      pending                <= '0;
      received               <= '0;
      best_len               <= '0;
      best_idx               <= '0;
      job_ready              <= 1'b1;
      match_req_valid        <= 1'b0;
      match_req_tag          <= '0;
      match_req_head_addr    <= '0;
      match_req_history_addr <= '0;
      match_resp_ready       <= 1'b0;
      res_valid              <= 1'b0;
      res_head_addr          <= '0;
      res_match_len          <= '0;
      res_offset             <= '0;
      res_cand_idx           <= '0;
    end else begin
      received <= received_nx;
      best_len <= best_len_nx;
      best_idx <= best_idx_nx;
      case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            job_ready  <= 1'b0;
            head_q     <= job_head_addr;
            cand_q     <= in_cand;
            issue_mask <= in_mask;
            received   <= '0;
            best_len   <= '0;
            best_idx   <= '0;
            job_seq    <= seq;
            seq        <= seq + SW'(1);
            if (in_mask == '0) begin
              state         <= OUTPUT;
              res_valid     <= 1'b1;
              res_head_addr <= job_head_addr;
              res_match_len <= '0;
              res_offset    <= '0;
              res_cand_idx  <= '0;
            end else begin
              state                  <= ISSUE;
              match_req_valid        <= 1'b1;
              match_req_tag          <= {seq, first_idx};
              match_req_head_addr    <= job_head_addr;
              match_req_history_addr <= in_cand[first_idx];
              pending                <= in_mask & ~(NUM_CAND'(1) << first_idx);
              match_resp_ready       <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (match_req_valid && match_req_ready) begin
            if (pending == '0) begin
              match_req_valid <= 1'b0;
              // The final response may land in the same cycle as the final request.
              if (received_nx == issue_mask) begin
                state            <= OUTPUT;
                match_resp_ready <= 1'b0;
                res_valid        <= 1'b1;
                res_head_addr    <= head_q;
                res_match_len    <= best_len_nx;
                res_offset       <= win_off;
                res_cand_idx     <= win_idx;
              end else begin
                state <= COLLECT;
              end
            end else begin
              match_req_tag          <= {job_seq, next_idx};
              match_req_history_addr <= cand_q[next_idx];
              pending                <= pending_nx & ~(NUM_CAND'(1) << next_idx);
            end
          end
        end
        COLLECT: begin
          if (received_nx == issue_mask) begin
            state            <= OUTPUT;
            match_resp_ready <= 1'b0;
            res_valid        <= 1'b1;
            res_head_addr    <= head_q;
            res_match_len    <= best_len_nx;
            res_offset       <= win_off;
            res_cand_idx     <= win_idx;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            job_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_job_issuer.sv
// Directed self-checking bench for match_job_issuer: ordering, filtering, backpressure,
// stale/duplicate/short responses and reset behaviour.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 8
`endif

module tb_match_job_issuer;
  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned LW = `MAX_MATCH_LEN_LOG2 + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 job_valid = 1'b0;
  logic                 job_ready;
  logic [AW-1:0]        job_head_addr = '0;
  logic [4*AW-1:0]      job_cand_addr = '0;
  logic [3:0]           job_cand_mask = '0;
  logic                 match_req_valid;
  logic                 match_req_ready = 1'b0;
  logic [7:0]           match_req_tag;
  logic [AW-1:0]        match_req_head_addr;
  logic [AW-1:0]        match_req_history_addr;
  logic                 match_resp_valid = 1'b0;
  logic                 match_resp_ready;
  logic [7:0]           match_resp_tag = '0;
  logic [LW-1:0]        match_resp_match_len = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [AW-1:0]        res_head_addr;
  logic [LW-1:0]        res_match_len;
  logic [AW-1:0]        res_offset;
  logic [1:0]           res_cand_idx;

  int n_checks = 0;
  int n_errors = 0;

  match_job_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_head_addr(job_head_addr),
    .job_cand_addr(job_cand_addr), .job_cand_mask(job_cand_mask),
    .match_req_valid(match_req_valid), .match_req_ready(match_req_ready),
    .match_req_tag(match_req_tag), .match_req_head_addr(match_req_head_addr),
    .match_req_history_addr(match_req_history_addr),
    .match_resp_valid(match_resp_valid), .match_resp_ready(match_resp_ready),
    .match_resp_tag(match_resp_tag), .match_resp_match_len(match_resp_match_len),
    .res_valid(res_valid), .res_ready(res_ready), .res_head_addr(res_head_addr),
    .res_match_len(res_match_len), .res_offset(res_offset), .res_cand_idx(res_cand_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [AW-1:0] head, input logic [AW-1:0] c0, input logic [AW-1:0] c1,
                          input logic [AW-1:0] c2, input logic [AW-1:0] c3, input logic [3:0] m);
    job_head_addr = head;
    job_cand_addr = {c3, c2, c1, c0};
    job_cand_mask = m;
    job_valid     = 1'b1;
    step();
    job_valid     = 1'b0;
  endtask

  task automatic resp(input logic [7:0] tag, input int len);
    match_resp_valid     = 1'b1;
    match_resp_tag       = tag;
    match_resp_match_len = LW'(len);
    step();
    match_resp_valid     = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if ({job_ready, match_req_valid, match_resp_ready, res_valid} !== 4'b1000) begin
      n_errors++;
      $display("FAIL %s_ctrl: got %b want 1000", name,
               {job_ready, match_req_valid, match_resp_ready, res_valid});
    end
    n_checks++;
    if ({match_req_tag, match_req_head_addr, match_req_history_addr, res_head_addr,
         res_match_len, res_offset, res_cand_idx} !== '0) begin
      n_errors++;
      $display("FAIL %s_data: tag %h rhead %0d hist %0d head %0d len %0d off %0d idx %0d want all 0",
               name, match_req_tag, match_req_head_addr, match_req_history_addr, res_head_addr,
               res_match_len, res_offset, res_cand_idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst_n = 1'b1;
  endtask

  // seq 0: four usable candidates, in-order responses 5,9,9,3
  task automatic test_in_order();
    int lens[4] = '{5, 9, 9, 3};
    match_req_ready = 1'b1;
    send_job(1000, 100, 200, 300, 400, 4'hF);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (!(match_req_valid === 1'b1 && match_req_tag === 8'(k) &&
            match_req_history_addr === AW'(100 * (k + 1)) && match_req_head_addr === AW'(1000))) begin
        n_errors++;
        $display("FAIL in_order_req%0d: valid %b tag %h hist %0d head %0d want 1 %h %0d 1000",
                 k, match_req_valid, match_req_tag, match_req_history_addr, match_req_head_addr,
                 8'(k), 100 * (k + 1));
      end
      step();
    end
    match_req_ready = 1'b0;
    n_checks++;
    if ({match_req_valid, match_resp_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL in_order_collect: req_valid,resp_ready %b want 01", {match_req_valid, match_resp_ready});
    end
    for (int k = 0; k < 4; k++) resp(8'(k), lens[k]);
    n_checks++;
    if (!(res_valid === 1'b1 && res_match_len === LW'(9) && res_cand_idx === 2'd1 &&
          res_offset === AW'(800) && res_head_addr === AW'(1000) && match_resp_ready === 1'b0)) begin
      n_errors++;
      $display("FAIL in_order_res: valid %b len %0d idx %0d off %0d head %0d rready %b want 1 9 1 800 1000 0",
               res_valid, res_match_len, res_cand_idx, res_offset, res_head_addr, match_resp_ready);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_checks++;
    if ({job_ready, res_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL in_order_done: job_ready,res_valid %b want 10", {job_ready, res_valid});
    end
  endtask

  // seq 1: responses for idx 3,2,0,1 with len 6,6,2,6
  task automatic test_out_of_order();
    int order[4] = '{3, 2, 0, 1};
    int lens[4]  = '{6, 6, 2, 6};
    match_req_ready = 1'b1;
    send_job(1000, 100, 200, 300, 400, 4'hF);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (match_req_tag !== 8'(4 + k) || match_req_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL ooo_tag%0d: got %h valid %b want %h", k, match_req_tag, match_req_valid, 8'(4 + k));
      end
      step();
    end
    match_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) resp(8'(4 + order[k]), lens[k]);
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ooo_early: res_valid %b want 0 after 3 responses", res_valid);
    end
    resp(8'(4 + order[3]), lens[3]);
    n_checks++;
    if (!(res_valid === 1'b1 && res_match_len === LW'(6) && res_cand_idx === 2'd1 &&
          res_offset === AW'(800))) begin
      n_errors++;
      $display("FAIL ooo_res: valid %b len %0d idx %0d off %0d want 1 6 1 800",
               res_valid, res_match_len, res_cand_idx, res_offset);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // seq 2: cand1 not behind head, cand2 outside the 32 KiB window
  task automatic test_filter();
    match_req_ready = 1'b1;
    send_job(40000, 39999, 40000, 5000, 20000, 4'hF);
    n_checks++;
    if (!(match_req_valid === 1'b1 && match_req_tag === 8'h08 && match_req_history_addr === AW'(39999))) begin
      n_errors++;
      $display("FAIL filter_req0: valid %b tag %h hist %0d want 1 08 39999",
               match_req_valid, match_req_tag, match_req_history_addr);
    end
    step();
    n_checks++;
    if (!(match_req_valid === 1'b1 && match_req_tag === 8'h0B && match_req_history_addr === AW'(20000))) begin
      n_errors++;
      $display("FAIL filter_req1: valid %b tag %h hist %0d want 1 0b 20000",
               match_req_valid, match_req_tag, match_req_history_addr);
    end
    step();
    match_req_ready = 1'b0;
    n_checks++;
    if (match_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL filter_req_end: valid %b want 0", match_req_valid);
    end
    resp(8'h09, 50);
    resp(8'h0B, 7);
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL filter_early: res_valid %b want 0", res_valid);
    end
    resp(8'h08, 4);
    n_checks++;
    if (!(res_valid === 1'b1 && res_match_len === LW'(7) && res_cand_idx === 2'd3 &&
          res_offset === AW'(20000) && res_head_addr === AW'(40000))) begin
      n_errors++;
      $display("FAIL filter_res: valid %b len %0d idx %0d off %0d head %0d want 1 7 3 20000 40000",
               res_valid, res_match_len, res_cand_idx, res_offset, res_head_addr);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // seq 3: no candidates present
  task automatic test_empty();
    send_job(500, 10, 20, 30, 40, 4'h0);
    n_checks++;
    if (!(match_req_valid === 1'b0 && res_valid === 1'b1 && res_match_len === '0 &&
          res_offset === '0 && res_cand_idx === '0 && res_head_addr === AW'(500))) begin
      n_errors++;
      $display("FAIL empty_res: req_valid %b res_valid %b len %0d off %0d idx %0d head %0d want 0 1 0 0 0 500",
               match_req_valid, res_valid, res_match_len, res_offset, res_cand_idx, res_head_addr);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // seq 4: same-cycle responses, request stall, result stall
  task automatic test_backpressure();
    int lens[4] = '{10, 4, 12, 12};
    match_req_ready = 1'b1;
    send_job(1000, 100, 200, 300, 400, 4'hF);
    match_resp_valid = 1'b1; match_resp_tag = 8'h10; match_resp_match_len = LW'(lens[0]);
    step();
    match_resp_valid = 1'b0;
    match_req_ready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (!(match_req_valid === 1'b1 && match_req_tag === 8'h11 && match_req_history_addr === AW'(200) &&
            match_req_head_addr === AW'(1000))) begin
        n_errors++;
        $display("FAIL bp_req_hold%0d: valid %b tag %h hist %0d head %0d want 1 11 200 1000",
                 c, match_req_valid, match_req_tag, match_req_history_addr, match_req_head_addr);
      end
      step();
    end
    match_req_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (match_req_tag !== 8'(16 + k)) begin
        n_errors++;
        $display("FAIL bp_tag%0d: got %h want %h", k, match_req_tag, 8'(16 + k));
      end
      match_resp_valid = 1'b1; match_resp_tag = 8'(16 + k); match_resp_match_len = LW'(lens[k]);
      step();
    end
    match_resp_valid = 1'b0;
    match_req_ready  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (!(res_valid === 1'b1 && res_match_len === LW'(12) && res_cand_idx === 2'd2 &&
            res_offset === AW'(700) && job_ready === 1'b0 && match_req_valid === 1'b0)) begin
        n_errors++;
        $display("FAIL bp_res_hold%0d: valid %b len %0d idx %0d off %0d job_ready %b req_valid %b want 1 12 2 700 0 0",
                 c, res_valid, res_match_len, res_cand_idx, res_offset, job_ready, match_req_valid);
      end
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_checks++;
    if ({job_ready, res_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL bp_done: job_ready,res_valid %b want 10", {job_ready, res_valid});
    end
  endtask

  // seq 5 interrupted by reset; seq restarts at 0
  task automatic test_mid_reset();
    match_req_ready = 1'b1;
    send_job(1000, 100, 200, 300, 400, 4'hF);
    step();
    match_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    check_reset_state("mid_reset");
    rst_n = 1'b1;
  endtask

  // seq 0: stale tag, duplicate, short lengths
  task automatic test_stale();
    match_req_ready = 1'b1;
    send_job(1000, 100, 200, 300, 400, 4'hF);
    n_checks++;
    if (match_req_tag !== 8'h00) begin
      n_errors++;
      $display("FAIL stale_seq: tag %h want 00", match_req_tag);
    end
    for (int k = 0; k < 4; k++) step();
    match_req_ready = 1'b0;
    resp(8'h04, 20);
    resp(8'h02, 8);
    resp(8'h02, 30);
    resp(8'h00, 3);
    resp(8'h01, 3);
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stale_early: res_valid %b want 0", res_valid);
    end
    resp(8'h03, 8);
    n_checks++;
    if (!(res_valid === 1'b1 && res_match_len === LW'(8) && res_cand_idx === 2'd2 &&
          res_offset === AW'(700))) begin
      n_errors++;
      $display("FAIL stale_res: valid %b len %0d idx %0d off %0d want 1 8 2 700",
               res_valid, res_match_len, res_cand_idx, res_offset);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // seq 1: single candidate whose length is below the minimum
  task automatic test_short_len();
    match_req_ready = 1'b1;
    send_job(1000, 100, 200, 300, 400, 4'h1);
    n_checks++;
    if (!(match_req_tag === 8'h04 && match_req_history_addr === AW'(100))) begin
      n_errors++;
      $display("FAIL short_req: tag %h hist %0d want 04 100", match_req_tag, match_req_history_addr);
    end
    step();
    match_req_ready = 1'b0;
    resp(8'h04, 3);
    n_checks++;
    if (!(res_valid === 1'b1 && res_match_len === '0 && res_offset === '0 && res_cand_idx === '0)) begin
      n_errors++;
      $display("FAIL short_res: valid %b len %0d off %0d idx %0d want 1 0 0 0",
               res_valid, res_match_len, res_offset, res_cand_idx);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_filter();
    test_empty();
    test_backpressure();
    test_mid_reset();
    test_stale();
    test_short_len();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
